// File: rtl/ldpc_syndrome_check_unit.sv
// ldpc_syndrome_check_unit
// -----------------------------------------------------------------------------
// Receive-side syndrome checker for a circulant-generated systematic code.
// A block arrives as M message bits and then M parity bits, Lm bits per beat.
// The unit rebuilds the parity from the message using the circulant generator
// row f. It then XORs the rebuilt parity with the received parity to form the
// syndrome. It reports the syndrome, an error flag and the syndrome weight,
// so that blocks that need full LDPC decoding can be picked out.
//
// Ports
//   clk_in      in   1   clock, rising edge
//   rst         in   1   asynchronous active-low reset
//   start       in   1   begin a block (honoured in IDLE / DONE only)
//   f_M         in   M   circulant generator row, captured on accepted start
//   in_valid    in   1   in_data holds a beat
//   in_ready    out  1   a beat is accepted this cycle when in_valid is high
//   in_data     in   Lm  message beat, then parity beat
//   busy        out  1   block in progress (LOAD_MSG / LOAD_PAR)
//   done        out  1   one-cycle pulse, result valid
//   syndrome    out  M   rebuilt parity XOR received parity
//   err         out  1   syndrome is nonzero
//   err_weight  out  WW  popcount of syndrome
// -----------------------------------------------------------------------------
module ldpc_syndrome_check_unit #(
  parameter int Lm = 16,
  parameter int M  = 32,
  parameter int WW = 6
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          start,
  input  logic [M-1:0]  f_M,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [Lm-1:0] in_data,
  output logic          busy,
  output logic          done,
  output logic [M-1:0]  syndrome,
  output logic          err,
  output logic [WW-1:0] err_weight
);

  localparam int NB = M / Lm;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LOAD_MSG = 2'd1,
    S_LOAD_PAR = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  // Rotate left by k: result bit j takes x[(j-k) mod M].
  function automatic logic [M-1:0] rotl(input logic [M-1:0] x, input int k);
    logic [M-1:0] r;
    r = '0;
    for (int j = 0; j < M; j++) begin
      r[j] = x[(j + M - k) % M];
    end
    return r;
  endfunction

  // Number of set bits in a syndrome word.
  function automatic logic [WW-1:0] popcount(input logic [M-1:0] v);
    logic [WW-1:0] n;
    n = '0;
    for (int j = 0; j < M; j++) begin
      n = n + WW'(v[j]);
    end
    return n;
  endfunction

  state_t         r_state;
  state_t         w_next_state;
  logic [M-1:0]   r_f;
  logic [M-1:0]   r_acc;
  logic [M-1:0]   r_syn;
  logic [CW-1:0]  r_cnt;
  logic           r_done;
  logic [M-1:0]   r_syndrome;
  logic           r_err;
  logic [WW-1:0]  r_err_weight;

  logic           w_in_ready;
  logic           w_accept;
  logic           w_last_beat;
  logic [M-1:0]   w_msg_term;
  logic [Lm-1:0]  w_acc_chunk;
  logic [M-1:0]   w_syn_final;

  assign w_in_ready  = (r_state == S_LOAD_MSG) || (r_state == S_LOAD_PAR);
  assign w_accept    = in_valid && w_in_ready;
  assign w_last_beat = (r_cnt == CW'(NB - 1));

  assign in_ready   = w_in_ready;
  assign busy       = w_in_ready;
  assign done       = r_done;
  assign syndrome   = r_syndrome;
  assign err        = r_err;
  assign err_weight = r_err_weight;

  // State register.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; DONE behaves exactly like IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_next_state = S_LOAD_MSG;
        end else begin
          w_next_state = r_state;
        end
      end
      S_LOAD_MSG: begin
        if (w_accept && w_last_beat) begin
          w_next_state = S_LOAD_PAR;
        end else begin
          w_next_state = S_LOAD_MSG;
        end
      end
      S_LOAD_PAR: begin
        if (w_accept && w_last_beat) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_LOAD_PAR;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Parity contribution of one message beat. r_f already holds f rotated by
  // the beat's base bit offset, so bit i of the beat needs only a rotation by i.
  always_comb begin
    w_msg_term = '0;
    for (int i = 0; i < Lm; i++) begin
      if (in_data[i]) begin
        w_msg_term = w_msg_term ^ rotl(r_f, i);
      end else begin
        w_msg_term = w_msg_term;
      end
    end
  end

  // Select the accumulator slice for the current parity beat and splice the
  // resulting syndrome slice into the partial syndrome.
  always_comb begin
    w_acc_chunk = '0;
    w_syn_final = r_syn;
    for (int c = 0; c < NB; c++) begin
      if (r_cnt == CW'(c)) begin
        w_acc_chunk                = r_acc[c*Lm +: Lm];
        w_syn_final[c*Lm +: Lm]    = r_acc[c*Lm +: Lm] ^ in_data;
      end else begin
        w_syn_final[c*Lm +: Lm]    = r_syn[c*Lm +: Lm];
      end
    end
  end

  // Datapath: generator row, accumulator, beat counter and registered results.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_f          <= '0;
      r_acc        <= '0;
      r_syn        <= '0;
      r_cnt        <= '0;
      r_done       <= 1'b0;
      r_syndrome   <= '0;
      r_err        <= 1'b0;
      r_err_weight <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_f   <= f_M;
            r_acc <= '0;
            r_syn <= '0;
            r_cnt <= '0;
          end
        end
        S_LOAD_MSG: begin
          if (w_accept) begin
            r_acc <= r_acc ^ w_msg_term;
            r_f   <= rotl(r_f, Lm);
            r_cnt <= w_last_beat ? '0 : r_cnt + CW'(1);
          end
        end
        S_LOAD_PAR: begin
          if (w_accept) begin
            r_syn <= w_syn_final;
            r_cnt <= w_last_beat ? '0 : r_cnt + CW'(1);
            if (w_last_beat) begin
              // Final slice is merged here so all three results land together.
              r_syndrome   <= w_syn_final;
              r_err        <= |w_syn_final;
              r_err_weight <= popcount(w_syn_final);
              r_done       <= 1'b1;
            end
          end
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
